// File: rtl/trigger_frame_gen.sv
// Multi-channel trigger frame generator: idle frames by default, BURST_LEN trigger frames per serviced event.
// Optional CRC8 over bytes [1]..[3+P] when TRIGGER_FRAME_CRC8_EN is defined (CRC byte fixed at 0x00 otherwise).
module trigger_frame_gen #(
  parameter int         NUM_CH        = 4,
  parameter int         PAYLOAD_BYTES = 4,
  parameter int         BURST_LEN     = 256,
  parameter logic [7:0] SOP           = 8'h3C,
  parameter logic [7:0] EOP           = 8'hBC,
  parameter logic [7:0] CTRL_BASE     = 8'h30
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CH-1:0]                         trigger_in,
  input  logic                                      tx_ready,
  output logic                                      tx_valid,
  output logic [7:0]                                tx_data,
  output logic                                      tx_sop,
  output logic                                      tx_eop,
  output logic                                      is_trigger,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] active_ch,
  output logic [NUM_CH-1:0]                         overrun
);
  localparam int FL    = PAYLOAD_BYTES + 6;
  localparam int IDX_W = $clog2(FL);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TS_W  = 8 * PAYLOAD_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FL - 1);
  localparam logic [IDX_W-1:0] CRC_IDX  = IDX_W'(FL - 2);
  localparam logic [IDX_W-1:0] CRC_LAST = IDX_W'(FL - 3);
  localparam logic [7:0]       SEQ_LAST = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_TRIG} state_t;

  state_t            state_reg;
  logic              tx_valid_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              is_trig_reg;
  logic [CH_W-1:0]   active_ch_reg;
  logic [7:0]        seq_reg;
  logic [TS_W-1:0]   burst_ts_reg;
  logic [TS_W-1:0]   ts_cnt_reg;
  logic [NUM_CH-1:0] trig_hist_reg;
  logic [NUM_CH-1:0] pending_reg;
  logic [NUM_CH-1:0] overrun_reg;
  logic [TS_W-1:0]   ts_reg [NUM_CH];

  logic [NUM_CH-1:0] pending_next;
  logic [NUM_CH-1:0] overrun_next;
  logic [NUM_CH-1:0] ts_load;
  logic [NUM_CH-1:0] trig_edge;
  logic [CH_W-1:0]   sel_ch;
  logic [7:0]        crc_byte;
  logic [7:0]        data_next;
  logic              accept;
  logic              frame_done;
  logic              burst_last;
  logic              burst_start;

  assign accept      = tx_valid_reg && tx_ready;
  assign frame_done  = accept && (idx_reg == LAST_IDX);
  assign burst_last  = (seq_reg == SEQ_LAST);
  assign burst_start = frame_done && ((state_reg == ST_WAIT) ||
                       ((state_reg == ST_TRIG) && burst_last && (|pending_reg)));
  assign trig_edge   = trigger_in & ~trig_hist_reg;

  always_comb begin
    sel_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_reg[i]) sel_ch = CH_W'(i);
    end
  end

  // A pending bit being cleared by this cycle's burst start no longer counts as pending,
  // so an edge arriving on that same cycle is a fresh event rather than an overrun.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic still_pending;
      assign still_pending    = pending_reg[gi] && !(burst_start && (sel_ch == CH_W'(gi)));
      assign pending_next[gi] = trig_edge[gi] || still_pending;
      assign overrun_next[gi] = overrun_reg[gi] || (trig_edge[gi] && still_pending);
      assign ts_load[gi]      = trig_edge[gi] && !still_pending;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_valid_reg  <= 1'b0;
      idx_reg       <= '0;
      state_reg     <= ST_IDLE;
      is_trig_reg   <= 1'b0;
      active_ch_reg <= '0;
      seq_reg       <= '0;
      burst_ts_reg  <= '0;
      ts_cnt_reg    <= '0;
      trig_hist_reg <= '1;
      pending_reg   <= '0;
      overrun_reg   <= '0;
      for (int i = 0; i < NUM_CH; i++) ts_reg[i] <= '0;
    end else begin
      tx_valid_reg  <= 1'b1;
      ts_cnt_reg    <= ts_cnt_reg + TS_W'(1);
      trig_hist_reg <= trigger_in;
      pending_reg   <= pending_next;
      overrun_reg   <= overrun_next;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ts_load[i]) ts_reg[i] <= ts_cnt_reg;
      end
      if (accept) idx_reg <= frame_done ? '0 : idx_reg + IDX_W'(1);

      case (state_reg)
        ST_IDLE: if (|pending_reg) state_reg <= ST_WAIT;
        ST_WAIT: state_reg <= ST_WAIT;
        ST_TRIG: begin
          if (frame_done) begin
            if (!burst_last) begin
              seq_reg <= seq_reg + 8'd1;
            end else if (!(|pending_reg)) begin
              state_reg   <= ST_IDLE;
              is_trig_reg <= 1'b0;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      // Burst start snapshots the channel timestamp so a re-queued event cannot alter this burst.
      if (burst_start) begin
        state_reg     <= ST_TRIG;
        is_trig_reg   <= 1'b1;
        active_ch_reg <= sel_ch;
        seq_reg       <= '0;
        burst_ts_reg  <= ts_reg[sel_ch];
      end
    end
  end

`ifdef TRIGGER_FRAME_CRC8_EN
  logic [7:0] crc_reg;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] r;
    r = crc ^ data;
    for (int b = 0; b < 8; b++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_reg <= 8'h00;
    end else if (accept && (idx_reg != '0) && (idx_reg <= CRC_LAST)) begin
      crc_reg <= crc8_step(crc_reg, tx_data);
    end else if (frame_done) begin
      crc_reg <= 8'h00;
    end
  end

  assign crc_byte = crc_reg;
`else
  assign crc_byte = 8'h00;
`endif

  always_comb begin
    data_next = 8'h00;
    if (idx_reg == '0) begin
      data_next = SOP;
    end else if (idx_reg == LAST_IDX) begin
      data_next = EOP;
    end else if (idx_reg == CRC_IDX) begin
      data_next = crc_byte;
    end else if (is_trig_reg) begin
      if (idx_reg == IDX_W'(1)) data_next = seq_reg;
      if (idx_reg == IDX_W'(2)) data_next = CTRL_BASE | 8'(active_ch_reg);
      for (int k = 0; k < PAYLOAD_BYTES; k++) begin
        if (idx_reg == IDX_W'(4 + k)) data_next = burst_ts_reg[8*(PAYLOAD_BYTES-1-k) +: 8];
      end
    end
  end

  assign tx_valid   = tx_valid_reg;
  assign tx_data    = data_next;
  assign tx_sop     = (idx_reg == '0);
  assign tx_eop     = (idx_reg == LAST_IDX);
  assign is_trigger = is_trig_reg;
  assign active_ch  = active_ch_reg;
  assign overrun    = overrun_reg;
endmodule

// File: tb/tb_trigger_frame_gen.sv
// Self-checking bench for trigger_frame_gen: randomized triggers/ready against a frame-level reference model.
module tb_trigger_frame_gen;
  localparam int NUM_CH = 4;
  localparam int P      = 4;
  localparam int FL     = P + 6;
  localparam int BL     = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] trigger_in;
  logic              tx_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_sop;
  logic              tx_eop;
  logic              is_trigger;
  logic [1:0]        active_ch;
  logic [NUM_CH-1:0] overrun;

  always #5 clk = ~clk;

  trigger_frame_gen #(.NUM_CH(NUM_CH), .PAYLOAD_BYTES(P), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .trigger_in(trigger_in), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .is_trigger(is_trigger), .active_ch(active_ch), .overrun(overrun)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: events per channel, and the frame currently on the wire.
  int                cyc;
  int                pos;
  bit                m_valid;
  bit                cur_trig;
  int                cur_ch;
  int                cur_seq;
  logic [31:0]       cur_ts;
  logic [7:0]        fb [FL];
  bit                m_pend [NUM_CH];
  int                m_set  [NUM_CH];
  logic [31:0]       m_ts   [NUM_CH];
  logic [NUM_CH-1:0] m_ovr;
  logic [NUM_CH-1:0] m_prev;
  logic [NUM_CH-1:0] tin;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, byte %0d)", tag, got, exp, cyc, pos);
    end
  endtask

`ifdef TRIGGER_FRAME_CRC8_EN
  // CRC as the remainder of the message times x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc();
    logic [7:0] r;
    logic       top;
    r = 8'h00;
    for (int b = 1; b <= 3 + P + 1; b++) begin
      for (int j = 7; j >= 0; j--) begin
        top = r[7];
        r   = {r[6:0], (b <= 3 + P) ? fb[b][j] : 1'b0};
        if (top) r = r ^ 8'h07;
      end
    end
    return r;
  endfunction
`endif

  task automatic build_frame();
    logic [7:0] seq8;
    logic [7:0] ch8;
    seq8 = cur_seq[7:0];
    ch8  = cur_ch[7:0];
    fb[0] = 8'h3C;
    fb[1] = cur_trig ? seq8 : 8'h00;
    fb[2] = cur_trig ? (8'h30 | ch8) : 8'h00;
    fb[3] = 8'h00;
    for (int k = 0; k < P; k++) fb[4+k] = cur_trig ? cur_ts[8*(P-1-k) +: 8] : 8'h00;
`ifdef TRIGGER_FRAME_CRC8_EN
    fb[4+P] = ref_crc();
`else
    fb[4+P] = 8'h00;
`endif
    fb[FL-1] = 8'hBC;
  endtask

  task automatic model_reset();
    cyc = 0; pos = 0; m_valid = 1'b0;
    cur_trig = 1'b0; cur_ch = 0; cur_seq = 0; cur_ts = '0;
    for (int c = 0; c < NUM_CH; c++) begin m_pend[c] = 1'b0; m_set[c] = 0; m_ts[c] = '0; end
    m_ovr = '0; m_prev = '1;
    build_frame();
  endtask

  // Next frame at a boundary: continue the burst, or start one for the lowest pending channel.
  // An idle frame leads into a burst only if the event was already pending two cycles before EOP.
  task automatic frame_boundary();
    bit go;
    int sel;
    go = 1'b0; sel = -1;
    if (cur_trig && cur_seq < BL - 1) begin
      cur_seq++;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_pend[c] && (cur_trig || m_set[c] <= cyc - 2)) go = 1'b1;
      end
      for (int c = NUM_CH - 1; c >= 0; c--) if (m_pend[c]) sel = c;
      if (go) begin
        cur_trig = 1'b1; cur_ch = sel; cur_seq = 0; cur_ts = m_ts[sel];
        m_pend[sel] = 1'b0;
      end else begin
        cur_trig = 1'b0;
      end
    end
  endtask

  task automatic model_clock(input logic [NUM_CH-1:0] trig, input logic rdy);
    if (rdy && m_valid) begin
      if (pos == FL - 1) begin
        frame_boundary();
        pos = 0;
        build_frame();
      end else begin
        pos++;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (trig[c] && !m_prev[c]) begin
        if (m_pend[c]) m_ovr[c] = 1'b1;
        else begin m_pend[c] = 1'b1; m_ts[c] = cyc; m_set[c] = cyc; end
      end
    end
    m_prev  = trig;
    m_valid = 1'b1;
    cyc++;
  endtask

  task automatic check_outputs();
    check_val("tx_valid", 32'(tx_valid), 32'(m_valid));
    check_val("tx_data", 32'(tx_data), 32'(fb[pos]));
    check_val("tx_sop", 32'(tx_sop), 32'(pos == 0));
    check_val("tx_eop", 32'(tx_eop), 32'(pos == FL - 1));
    check_val("is_trigger", 32'(is_trigger), 32'(cur_trig));
    if (cur_trig) check_val("active_ch", 32'(active_ch), 32'(cur_ch));
    check_val("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic step(input logic [NUM_CH-1:0] trig, input logic rdy);
    trigger_in = trig;
    tx_ready   = rdy;
    check_outputs();
    model_clock(trig, rdy);
    @(posedge clk);
    #1;
    if (n_err >= 50) begin
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  endtask

  task automatic do_reset(input int n, input logic [NUM_CH-1:0] trig);
    reset = 1'b1; trigger_in = trig; tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_val("rst_valid", 32'(tx_valid), 32'd0);
      check_val("rst_data", 32'(tx_data), 32'h3C);
      check_val("rst_sop", 32'(tx_sop), 32'd1);
      check_val("rst_eop", 32'(tx_eop), 32'd0);
      check_val("rst_is_trigger", 32'(is_trigger), 32'd0);
      check_val("rst_active_ch", 32'(active_ch), 32'd0);
      check_val("rst_overrun", 32'(overrun), 32'd0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_sop(input logic rdy);
    for (int i = 0; i < 60; i++) begin
      if (tx_sop && tx_valid) break;
      step(tin, rdy);
    end
    check_val("sop_wait", 32'(tx_sop), 32'd1);
  endtask

  initial begin
    reset = 1'b1; trigger_in = '1; tx_ready = 1'b1; tin = '1;
    model_reset();

    // Triggers held high across reset release: idle frames only, no overrun.
    do_reset(3, tin);
    for (int i = 0; i < 40; i++) step(tin, 1'b1);
    tin = '0;
    for (int i = 0; i < 5; i++) step(tin, 1'b1);

    // Single ch2 edge mid-frame.
    wait_sop(1'b1);
    for (int i = 0; i < 3; i++) step(tin, 1'b1);
    step(4'b0100, 1'b1);
    for (int i = 0; i < 2650; i++) step(tin, 1'b1);

    // Simultaneous ch0 and ch3 edges.
    wait_sop(1'b1);
    for (int i = 0; i < 5; i++) step(tin, 1'b1);
    step(4'b1001, 1'b1);
    for (int i = 0; i < 5240; i++) step(tin, 1'b1);

    // Second ch1 edge before its burst starts.
    wait_sop(1'b1);
    step(tin, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b1);
    for (int i = 0; i < 2650; i++) step(tin, 1'b1);

    // Random triggers with ~50% ready.
    for (int i = 0; i < 30000; i++) begin
      for (int c = 0; c < NUM_CH; c++) if ($urandom_range(0, 399) == 0) tin[c] = ~tin[c];
      step(tin, 1'($urandom_range(0, 1)));
    end

    // Reset mid-frame, then resume with random ready.
    wait_sop(1'b1);
    for (int i = 0; i < 4; i++) step(tin, 1'b1);
    tin = 4'($urandom_range(0, 15));
    do_reset(2, tin);
    for (int i = 0; i < 60; i++) step(tin, 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
